rgb_pixel_packer: RTL and testbench
===================================

Name: rgb_pixel_packer

Overview:
- Converts a stream of 24-bit RGB pixels (one per accepted beat) into a 32-bit AXI4-Stream video stream.
- Packs 4 pixels into 3 output words.
- Sits between the fractal pixel generator and the video DMA / VDMA.
- Carries start-of-frame on tuser and end-of-line on tlast.

Parameters:
- None. Widths are fixed: 8 bits per colour, 32-bit output word.

Ports:
- aclk  input  1  clock; all logic on rising edge
- aresetn  input  1  reset; synchronous, active-high (asserted = 1), sampled on aclk
- r  input  8  red component of current pixel
- g  input  8  green component
- b  input  8  blue component
- valid  input  1  current pixel is valid
- sof  input  1  current pixel is first pixel of frame
- eol  input  1  current pixel is last pixel of line
- in_stream_ready  output  1  packer accepts the pixel this cycle
- out_stream_tdata  output  32  packed pixel bytes
- out_stream_tkeep  output  4  byte enables
- out_stream_tlast  output  1  last word of line
- out_stream_tready  input  1  downstream ready
- out_stream_tvalid  output  1  output word valid
- out_stream_tuser  output  1  first word of frame

Behaviour:
- **Pixel value:** P = {r, g, b}, so r = P[23:16] and b = P[7:0].
- **Accept:** accept = valid && in_stream_ready.
- **in_stream_ready** = !aresetn && (!out_stream_tvalid || out_stream_tready). It is combinational and is 0 while reset is asserted.
- **Phase counter:** 2-bit phase (0..3). Each accept advances the phase (3 wraps to 0).
  - Phase 0: store P into hold[23:0]. No word emitted.
  - Phase 1: emit {P[7:0], hold[23:0]}. Store P[23:8] into hold[15:0].
  - Phase 2: emit {P[15:0], hold[15:0]}. Store P[23:16] into hold[7:0].
  - Phase 3: emit {P, hold[7:0]}.
- **Emitting a word:** registered. On the accepting edge load tdata/tkeep/tlast/tuser and set tvalid=1. The word is visible the next cycle (latency 1 cycle after the accept completing it).
- **Output hold:**
  - If tvalid && tready and no new word is emitted that edge, clear tvalid.
  - While tvalid && !tready, hold all outputs stable; in_stream_ready=0.
- **tkeep:** 4'hF on all words except eol-flush words.
- **sof:**
  - Sets a pending-sof flag. tuser=1 on the first word emitted containing that pixel's bytes; flag clears when that word is loaded.
  - sof on an accept in phase 1..3 first resynchronises: discard hold bytes and treat the pixel as phase 0.
- **eol:**
  - Phase 3: the emitted word carries tlast=1; phase returns to 0.
  - Phase 0 (flush): emit {8'h00, P} with tkeep=4'b0111, tlast=1.
  - Phase 1: emit the normal word with tlast=1; P[23:8] is discarded.
  - Phase 2: emit the normal word with tlast=1; P[23:16] is discarded.
  - In all eol cases the phase returns to 0.
  - Line lengths that are multiples of 4 (e.g. 1920) never lose data.
- **sof and eol on the same accept:** handled as a phase-0 eol flush with tuser=1.
- **Reset values:** tvalid=0, tdata=0, tkeep=4'hF, tlast=0, tuser=0, phase=0, hold=0, pending-sof=0.
- **Reset mid-operation:** an in-flight word is dropped; partial hold bytes are discarded.

Optional Feature:
- Macro: PACKER_BGR_ORDER_EN.
- Defined: P = {b, g, r}, so r occupies the lowest byte of each pixel.
- Undefined: P = {r, g, b}.
- Packing, phase, and flag logic are identical in both cases.

Test Plan:
1. **Basic packing:** reset, tready=1; feed P0=010203, P1=040506, P2=070809, P3=0A0B0C (r,g,b bytes) on consecutive cycles with valid=1.
   - Expect words 32'h06010203, 32'h08090405, 32'h0A0B0C07, each one cycle after P1/P2/P3.
   - tkeep=F, tlast=0.
2. **sof:** same sequence with sof=1 on P0 → tuser=1 only on word 32'h06010203; eol=1 on P3 → tlast=1 only on 32'h0A0B0C07.
3. **Backpressure:** tready=0 after first word → tvalid stays 1, tdata stable at 32'h06010203, in_stream_ready=0; raise tready → word consumed, in_stream_ready=1 the same cycle, stream continues without loss.
4. **eol flush at phase 0:** single pixel 112233 with eol=1 → word 32'h00112233, tkeep=4'b0111, tlast=1; the next 4 pixels pack from phase 0.
5. **Resync on sof:** feed 2 pixels, then sof pixel 0A0B0C followed by 3 pixels → first word after resync has tuser=1 and low 24 bits 0x0A0B0C.
6. **Reset mid-stream:** assert aresetn=1 for 1 cycle mid-stream → tvalid=0, tuser=0, tlast=0, in_stream_ready=0 during reset; packing restarts at phase 0.

Source files
------------

// File: rtl/rgb_pixel_packer.sv
// Packs a stream of 24-bit RGB pixels into 32-bit AXI4-Stream words (4 pixels -> 3 words),
// carrying start-of-frame on tuser and end-of-line on tlast. Define PACKER_BGR_ORDER_EN for {b,g,r} pixel order.
module rgb_pixel_packer (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  input  logic        out_stream_tready,
  output logic        out_stream_tvalid,
  output logic        out_stream_tuser
);

  // Handshake: a pixel moves when valid && in_stream_ready; an output word moves when
  // out_stream_tvalid && out_stream_tready. The output slot is a single register, so the
  // input side only accepts when that slot is empty or draining this cycle.

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

  phase_e      phase_q, phase_d, eff_phase;
  logic [23:0] pix;
  logic [23:0] hold_q, hold_d;
  logic        sof_pend_q, sof_pend_d;
  logic [31:0] tdata_q, tdata_d;
  logic [3:0]  tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic        tvalid_q, tvalid_d;
  logic        accept;
  logic        emit;
  logic [31:0] word;
  logic [3:0]  word_keep;

`ifdef PACKER_BGR_ORDER_EN
  assign pix = {b, g, r};
`else
  assign pix = {r, g, b};
`endif

  assign in_stream_ready = !aresetn && (!tvalid_q || out_stream_tready);
  assign accept          = valid && in_stream_ready;
  // A sof pixel always restarts packing at phase 0, dropping any partial hold bytes.
  assign eff_phase       = sof ? PH0 : phase_q;

  // State register
  always_ff @(posedge aclk) begin
    if (aresetn) phase_q <= PH0;
    else         phase_q <= phase_d;
  end

  // Next-state logic
  always_comb begin
    phase_d = phase_q;
    if (accept) begin
      if (eol) begin
        phase_d = PH0;
      end else begin
        case (eff_phase)
          PH0: phase_d = PH1;
          PH1: phase_d = PH2;
          PH2: phase_d = PH3;
          PH3: phase_d = PH0;
        endcase
      end
    end
  end

  // Output logic: word assembly and hold-register update
  always_comb begin
    emit      = 1'b0;
    word      = 32'h0;
    word_keep = 4'hF;
    hold_d    = hold_q;
    if (accept) begin
      case (eff_phase)
        PH0: begin
          if (eol) begin
            emit      = 1'b1;
            word      = {8'h00, pix};
            word_keep = 4'b0111;
          end else begin
            hold_d = pix;
          end
        end
        PH1: begin
          emit = 1'b1;
          word = {pix[7:0], hold_q};
          if (!eol) hold_d = {8'h00, pix[23:8]};
        end
        PH2: begin
          emit = 1'b1;
          word = {pix[15:0], hold_q[15:0]};
          if (!eol) hold_d = {16'h0000, pix[23:16]};
        end
        PH3: begin
          emit = 1'b1;
          word = {pix, hold_q[7:0]};
        end
      endcase
    end
  end

  always_comb begin
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    sof_pend_d = sof_pend_q;
    if (accept && sof) sof_pend_d = 1'b1;
    if (emit) begin
      tvalid_d   = 1'b1;
      tdata_d    = word;
      tkeep_d    = word_keep;
      tlast_d    = eol;
      tuser_d    = sof_pend_q || sof;
      sof_pend_d = 1'b0;
    end else if (tvalid_q && out_stream_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      hold_q     <= 24'h0;
      sof_pend_q <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= 32'h0;
      tkeep_q    <= 4'hF;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      sof_pend_q <= sof_pend_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
    end
  end

  assign out_stream_tvalid = tvalid_q;
  assign out_stream_tdata  = tdata_q;
  assign out_stream_tkeep  = tkeep_q;
  assign out_stream_tlast  = tlast_q;
  assign out_stream_tuser  = tuser_q;

endmodule

// File: tb/tb_rgb_pixel_packer.sv
// Bench for rgb_pixel_packer: directed vector table, then random traffic against a
// byte-queue reference model.
module tb_rgb_pixel_packer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  r, g, b;
  logic        valid, sof, eol;
  logic        in_stream_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tready;
  logic        out_stream_tvalid;
  logic        out_stream_tuser;

  int total = 0;
  int bad   = 0;

  rgb_pixel_packer dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .valid             (valid),
    .sof               (sof),
    .eol               (eol),
    .in_stream_ready   (in_stream_ready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tready (out_stream_tready),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tuser  (out_stream_tuser)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] cur_pix();
`ifdef PACKER_BGR_ORDER_EN
    return {b, g, r};
`else
    return {r, g, b};
`endif
  endfunction

  task automatic drive(input logic rst_i, input logic v_i, input logic s_i, input logic e_i,
                       input logic rdy_i, input logic [23:0] p);
    aresetn           = rst_i;
    valid             = v_i;
    sof               = s_i;
    eol               = e_i;
    out_stream_tready = rdy_i;
`ifdef PACKER_BGR_ORDER_EN
    {b, g, r} = p;
`else
    {r, g, b} = p;
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, vld, sf, el, rdy;
    logic [23:0] pix;
    logic        e_ready;   // combinational ready before the edge
    logic        e_tvalid;  // outputs after the edge
    logic [31:0] e_data;
    logic [3:0]  e_keep;
    logic        e_last, e_user;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rst_i, input logic v_i, input logic s_i, input logic e_i,
                   input logic rdy_i, input logic [23:0] p, input logic er, input logic ev,
                   input logic [31:0] ed, input logic [3:0] ek, input logic el, input logic eu);
    vec_t t;
    t.rst = rst_i; t.vld = v_i; t.sf = s_i; t.el = e_i; t.rdy = rdy_i; t.pix = p;
    t.e_ready = er; t.e_tvalid = ev; t.e_data = ed; t.e_keep = ek; t.e_last = el; t.e_user = eu;
    vecs.push_back(t);
  endtask

  task automatic fill_table();
    // rst vld sof eol rdy pix        | ready tvalid data         keep  last user
    v(1, 0, 0, 0, 1, 24'h000000,        0, 0, 32'h00000000, 4'hF, 0, 0);
    // basic packing
    v(0, 1, 0, 0, 1, 24'h010203,        1, 0, 32'h0,        4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h040506,        1, 1, 32'h06010203, 4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h070809,        1, 1, 32'h08090405, 4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h0A0B0C,        1, 1, 32'h0A0B0C07, 4'hF, 0, 0);
    v(0, 0, 0, 0, 1, 24'h000000,        1, 0, 32'h0,        4'hF, 0, 0);
    // sof on first pixel, eol on fourth
    v(0, 1, 1, 0, 1, 24'h010203,        1, 0, 32'h0,        4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h040506,        1, 1, 32'h06010203, 4'hF, 0, 1);
    v(0, 1, 0, 0, 1, 24'h070809,        1, 1, 32'h08090405, 4'hF, 0, 0);
    v(0, 1, 0, 1, 1, 24'h0A0B0C,        1, 1, 32'h0A0B0C07, 4'hF, 1, 0);
    v(0, 0, 0, 0, 1, 24'h000000,        1, 0, 32'h0,        4'hF, 0, 0);
    // backpressure
    v(0, 1, 0, 0, 1, 24'h010203,        1, 0, 32'h0,        4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h040506,        1, 1, 32'h06010203, 4'hF, 0, 0);
    v(0, 1, 0, 0, 0, 24'h070809,        0, 1, 32'h06010203, 4'hF, 0, 0);
    v(0, 1, 0, 0, 0, 24'h070809,        0, 1, 32'h06010203, 4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h070809,        1, 1, 32'h08090405, 4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h0A0B0C,        1, 1, 32'h0A0B0C07, 4'hF, 0, 0);
    v(0, 0, 0, 0, 1, 24'h000000,        1, 0, 32'h0,        4'hF, 0, 0);
    // eol flush at phase 0, then normal packing
    v(0, 1, 0, 1, 1, 24'h112233,        1, 1, 32'h00112233, 4'h7, 1, 0);
    v(0, 1, 0, 0, 1, 24'h010203,        1, 0, 32'h0,        4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h040506,        1, 1, 32'h06010203, 4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h070809,        1, 1, 32'h08090405, 4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h0A0B0C,        1, 1, 32'h0A0B0C07, 4'hF, 0, 0);
    v(0, 0, 0, 0, 1, 24'h000000,        1, 0, 32'h0,        4'hF, 0, 0);
    // resync on sof after two pixels
    v(0, 1, 0, 0, 1, 24'h010203,        1, 0, 32'h0,        4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h040506,        1, 1, 32'h06010203, 4'hF, 0, 0);
    v(0, 1, 1, 0, 1, 24'h0A0B0C,        1, 0, 32'h0,        4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h0D0E0F,        1, 1, 32'h0F0A0B0C, 4'hF, 0, 1);
    v(0, 1, 0, 0, 1, 24'h101112,        1, 1, 32'h11120D0E, 4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h131415,        1, 1, 32'h13141510, 4'hF, 0, 0);
    v(0, 0, 0, 0, 1, 24'h000000,        1, 0, 32'h0,        4'hF, 0, 0);
    // reset mid-stream drops the pending word and hold bytes
    v(0, 1, 0, 0, 1, 24'h010203,        1, 0, 32'h0,        4'hF, 0, 0);
    v(0, 1, 1, 0, 1, 24'h040506,        1, 0, 32'h0,        4'hF, 0, 0);
    v(0, 1, 0, 0, 0, 24'h070809,        1, 1, 32'h09040506, 4'hF, 0, 1);
    v(1, 1, 0, 0, 0, 24'h0A0B0C,        0, 0, 32'h00000000, 4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h0A0B0C,        1, 0, 32'h0,        4'hF, 0, 0);
    v(0, 1, 0, 0, 1, 24'h010203,        1, 1, 32'h030A0B0C, 4'hF, 0, 0);
    v(0, 0, 0, 0, 1, 24'h000000,        1, 0, 32'h0,        4'hF, 0, 0);
  endtask

  // ---------------- reference model ----------------
  // Pixels become a little-endian byte stream; every 4 bytes form a word. sof empties the
  // byte stream; eol flushes a lone 3-byte pixel padded with 0 and drops any other leftover.
  logic [7:0]  bq[$];
  logic [37:0] exp_q[$];          // {data, keep, last, user}
  logic        m_tvalid  = 1'b0;
  logic        m_pending = 1'b0;

  task automatic model_check();
    logic er;
    er = !aresetn && (!m_tvalid || out_stream_tready);
    chk("rand_ready", {31'b0, in_stream_ready}, {31'b0, er});
    chk("rand_tvalid", {31'b0, out_stream_tvalid}, {31'b0, m_tvalid});
    if (m_tvalid && exp_q.size() > 0) begin
      chk("rand_tdata", out_stream_tdata, exp_q[0][37:6]);
      chk("rand_tkeep", {28'b0, out_stream_tkeep}, {28'b0, exp_q[0][5:2]});
      chk("rand_tlast", {31'b0, out_stream_tlast}, {31'b0, exp_q[0][1]});
      chk("rand_tuser", {31'b0, out_stream_tuser}, {31'b0, exp_q[0][0]});
    end
  endtask

  task automatic model_step();
    logic        er;
    logic        emitted;
    logic [23:0] p;
    logic [31:0] w;
    er = !aresetn && (!m_tvalid || out_stream_tready);
    if (aresetn) begin
      bq.delete(); exp_q.delete(); m_tvalid = 1'b0; m_pending = 1'b0;
      return;
    end
    if (m_tvalid && out_stream_tready) begin
      void'(exp_q.pop_front());
      m_tvalid = 1'b0;
    end
    if (valid && er) begin
      emitted = 1'b0;
      p = cur_pix();
      if (sof) begin
        bq.delete();
        m_pending = 1'b1;
      end
      bq.push_back(p[7:0]); bq.push_back(p[15:8]); bq.push_back(p[23:16]);
      if (bq.size() >= 4) begin
        w = {bq[3], bq[2], bq[1], bq[0]};
        for (int k = 0; k < 4; k++) void'(bq.pop_front());
        exp_q.push_back({w, 4'hF, eol, m_pending});
        m_pending = 1'b0;
        emitted = 1'b1;
      end
      if (eol) begin
        if (bq.size() == 3) begin
          exp_q.push_back({8'h00, bq[2], bq[1], bq[0], 4'b0111, 1'b1, m_pending});
          m_pending = 1'b0;
          emitted = 1'b1;
        end
        bq.delete();
      end
      if (emitted) m_tvalid = 1'b1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive(1, 0, 0, 0, 1, 24'h0);
    fill_table();
    @(posedge aclk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].sf, vecs[i].el, vecs[i].rdy, vecs[i].pix);
      #1;
      chk($sformatf("vec%0d_ready", i), {31'b0, in_stream_ready}, {31'b0, vecs[i].e_ready});
      @(posedge aclk); #1;
      chk($sformatf("vec%0d_tvalid", i), {31'b0, out_stream_tvalid}, {31'b0, vecs[i].e_tvalid});
      if (vecs[i].e_tvalid || vecs[i].rst) begin
        chk($sformatf("vec%0d_tdata", i), out_stream_tdata, vecs[i].e_data);
        chk($sformatf("vec%0d_tkeep", i), {28'b0, out_stream_tkeep}, {28'b0, vecs[i].e_keep});
        chk($sformatf("vec%0d_tlast", i), {31'b0, out_stream_tlast}, {31'b0, vecs[i].e_last});
        chk($sformatf("vec%0d_tuser", i), {31'b0, out_stream_tuser}, {31'b0, vecs[i].e_user});
      end
    end

    // randomized traffic against the byte-queue model
    for (int n = 0; n < 3000; n++) begin
      drive((n < 2) || ($urandom_range(0, 299) == 0),
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) < 7,
            24'($urandom));
      #1;
      model_check();
      model_step();
      @(posedge aclk); #1;
    end
    drive(0, 0, 0, 0, 1, 24'h0);
    #1;
    model_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
